// File: rtl/lfsr_prng.sv
// Parametrised Fibonacci LFSR pseudo-random source with valid/ready delivery,
// runtime seed load, all-zero lockup recovery and a delivered-word counter.
module lfsr_prng_chk #(
  parameter int unsigned  W     = 32,
  parameter logic [W-1:0] SEED  = 32'h00B2_91AE,
  parameter int unsigned  STEPS = 1
) (
  input logic         clk_i,
  input logic         reset_i,
  input logic         load_i,
  input logic         ready_i,
  input logic         valid_i,
  input logic [W-1:0] data_i
);
  // A zero seed would make the fallback path lock up the generator.
  if (SEED == {W{1'b0}}) begin : g_seed_zero
    $error("lfsr_prng: SEED must be non-zero");
  end

  if ((STEPS < 1) || (STEPS > W) || (W < 4)) begin : g_bad_geometry
    $error("lfsr_prng: need W >= 4 and 1 <= STEPS <= W");
  end

  property p_state_nonzero;
    @(posedge clk_i) disable iff (reset_i) (data_i != {W{1'b0}});
  endproperty
  a_state_nonzero: assert property (p_state_nonzero);

  // Offered words stay put until they are taken or a load overrides them.
  property p_stable_under_backpressure;
    @(posedge clk_i) disable iff (reset_i)
      (valid_i && !ready_i && !load_i) |=> (valid_i && $stable(data_i));
  endproperty
  a_stable_under_backpressure: assert property (p_stable_under_backpressure);
endmodule

module lfsr_prng #(
  parameter int unsigned  W     = 32,
  parameter logic [W-1:0] TAPS  = 32'h088C_8892,
  parameter logic [W-1:0] SEED  = 32'h00B2_91AE,
  parameter int unsigned  STEPS = 1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] seed_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         lockup_o,
  output logic [31:0]  count_o
);
  localparam logic [W-1:0] ZERO_W = {W{1'b0}};

  function automatic logic parity_f(input logic [W-1:0] v);
    return ^v;
  endfunction

  function automatic logic [W-1:0] step_f(input logic [W-1:0] s);
    return {s[W-2:0], parity_f(s & TAPS)};
  endfunction

  // Intermediate zeros are tolerated; only the delivered word is screened.
  function automatic logic [W-1:0] word_f(input logic [W-1:0] s);
    logic [W-1:0] t;
    t = s;
    for (int unsigned i = 0; i < STEPS; i++) begin
      t = step_f(t);
    end
    return t;
  endfunction

  logic [W-1:0] state_r;
  logic         valid_r;
  logic         lockup_r;
  logic [31:0]  count_r;

  logic [W-1:0] word_next_s;
  logic [W-1:0] state_nxt_s;
  logic         valid_nxt_s;
  logic         lockup_nxt_s;
  logic [31:0]  count_nxt_s;

  // Next-state selection: load beats handshake beats idle/request.
  always_comb begin
    word_next_s  = word_f(state_r);
    state_nxt_s  = state_r;
    valid_nxt_s  = valid_r;
    lockup_nxt_s = 1'b0;
    count_nxt_s  = count_r;
    if (load_i) begin
      if (seed_i != ZERO_W) begin
        state_nxt_s = seed_i;
      end else begin
        state_nxt_s = SEED;
      end
      valid_nxt_s = 1'b0;
      count_nxt_s = 32'd0;
    end else if (valid_r && ready_i) begin
      if (word_next_s == ZERO_W) begin
        state_nxt_s  = SEED;
        lockup_nxt_s = 1'b1;
      end else begin
        state_nxt_s = word_next_s;
      end
      count_nxt_s = count_r + 32'd1;
      valid_nxt_s = en_i;
    end else if (!valid_r && en_i) begin
      valid_nxt_s = 1'b1;
    end else begin
      valid_nxt_s = valid_r;
    end
  end

  // State registers with asynchronous reset to the seed.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r  <= SEED;
      valid_r  <= 1'b0;
      lockup_r <= 1'b0;
      count_r  <= 32'd0;
    end else begin
      state_r  <= state_nxt_s;
      valid_r  <= valid_nxt_s;
      lockup_r <= lockup_nxt_s;
      count_r  <= count_nxt_s;
    end
  end

  assign data_o   = state_r;
  assign valid_o  = valid_r;
  assign lockup_o = lockup_r;
  assign count_o  = count_r;

  lfsr_prng_chk #(
    .W     (W),
    .SEED  (SEED),
    .STEPS (STEPS)
  ) u_chk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (load_i),
    .ready_i (ready_i),
    .valid_i (valid_r),
    .data_i  (state_r)
  );
endmodule

// File: tb/tb_lfsr_prng.sv
// Self-checking bench for lfsr_prng: scoreboard of accepted words on the default
// instance plus directed checks on a STEPS=2 and a 4-bit lockup instance.
module tb_lfsr_prng;
  localparam logic [31:0] SEED_D = 32'h00B2_91AE;
  localparam logic [31:0] TAPS_D = 32'h088C_8892;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        en = 1'b0, load = 1'b0, ready = 1'b0;
  logic [31:0] seed = 32'd0;
  logic        valid, lockup;
  logic [31:0] data, count;

  logic        en2 = 1'b0, ready2 = 1'b0;
  logic        valid2, lockup2;
  logic [31:0] data2, count2;

  logic        en4 = 1'b0, load4 = 1'b0, ready4 = 1'b0;
  logic [3:0]  seed4 = 4'd0;
  logic        valid4, lockup4;
  logic [3:0]  data4;
  logic [31:0] count4;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];
  logic [31:0] w;

  always #5 clk = ~clk;

  lfsr_prng dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en), .load_i(load), .seed_i(seed),
    .ready_i(ready), .valid_o(valid), .data_o(data), .lockup_o(lockup), .count_o(count)
  );

  lfsr_prng #(.STEPS(2)) dut2 (
    .clk_i(clk), .reset_i(reset_i), .en_i(en2), .load_i(1'b0), .seed_i(32'd0),
    .ready_i(ready2), .valid_o(valid2), .data_o(data2), .lockup_o(lockup2), .count_o(count2)
  );

  lfsr_prng #(.W(4), .TAPS(4'h1), .SEED(4'h1), .STEPS(1)) dut4 (
    .clk_i(clk), .reset_i(reset_i), .en_i(en4), .load_i(load4), .seed_i(seed4),
    .ready_i(ready4), .valid_o(valid4), .data_o(data4), .lockup_o(lockup4), .count_o(count4)
  );

  function automatic logic [31:0] m_step(input logic [31:0] s);
    return {s[30:0], ^(s & TAPS_D)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every handshake about to happen pops the expected word.
  always @(negedge clk) begin
    if (!reset_i && valid && ready && !load) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        chk("sb_word", data, sb_q.pop_front());
      end
    end
  end

  initial begin
    #12 reset_i = 1'b0;
    tick();
    chk("rst_data", data, 32'h00B2_91AE);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_count", count, 32'd0);
    chk("rst_lockup", 32'(lockup), 32'd0);

    // en from cycle 0, ready from cycle 2
    en = 1'b1;
    chk("pre_valid", 32'(valid), 32'd0);
    tick();
    chk("valid_c1", 32'(valid), 32'd1);
    sb_q.push_back(32'h00B2_91AE);
    sb_q.push_back(32'h0165_235C);
    sb_q.push_back(32'h02CA_46B8);
    tick();
    ready = 1'b1;
    repeat (3) tick();
    ready = 1'b0;
    chk("count_3", count, 32'd3);
    w = m_step(32'h02CA_46B8);
    chk("word4", data, w);

    // backpressure with en toggling
    for (int i = 0; i < 5; i++) begin
      en = ~en;
      tick();
      chk("bp_data", data, w);
      chk("bp_valid", 32'(valid), 32'd1);
    end
    en = 1'b1;

    // release: exactly one advance per accepted cycle
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(w);
      w = m_step(w);
    end
    ready = 1'b1;
    repeat (3) tick();
    ready = 1'b0;
    chk("rel_data", data, w);
    chk("rel_count", count, 32'd6);

    // load colliding with a handshake
    load = 1'b1; seed = 32'h1234_5678; ready = 1'b1;
    tick();
    load = 1'b0; ready = 1'b0;
    chk("ld_data", data, 32'h1234_5678);
    chk("ld_valid", 32'(valid), 32'd0);
    chk("ld_count", count, 32'd0);
    tick();
    chk("ld_valid_back", 32'(valid), 32'd1);
    sb_q.push_back(32'h1234_5678);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("ld_adv", data, m_step(32'h1234_5678));
    chk("ld_count1", count, 32'd1);

    // zero seed falls back to SEED
    load = 1'b1; seed = 32'd0;
    tick();
    load = 1'b0;
    chk("zs_data", data, SEED_D);
    chk("zs_valid", 32'(valid), 32'd0);
    sb_q.push_back(SEED_D);
    sb_q.push_back(m_step(SEED_D));
    ready = 1'b1;
    repeat (3) tick();
    chk("zs_count", count, 32'd2);

    // asynchronous reset mid-stream
    #2 reset_i = 1'b1;
    #1;
    chk("ar_data", data, SEED_D);
    chk("ar_valid", 32'(valid), 32'd0);
    chk("ar_count", count, 32'd0);
    ready = 1'b0; en = 1'b0;
    tick();
    reset_i = 1'b0;
    tick();

    // STEPS = 2 instance
    en2 = 1'b1;
    tick();
    chk("s2_valid", 32'(valid2), 32'd1);
    ready2 = 1'b1;
    tick();
    ready2 = 1'b0;
    chk("s2_data", data2, m_step(m_step(SEED_D)));
    chk("s2_const", data2, 32'h02CA_46B8);
    chk("s2_count", count2, 32'd1);

    // 4-bit lockup instance
    load4 = 1'b1; seed4 = 4'h8; en4 = 1'b1;
    tick();
    load4 = 1'b0;
    chk("lk_load", 32'(data4), 32'h8);
    tick();
    chk("lk_valid", 32'(valid4), 32'd1);
    chk("lk_quiet", 32'(lockup4), 32'd0);
    ready4 = 1'b1;
    tick();
    ready4 = 1'b0;
    chk("lk_data", 32'(data4), 32'h1);
    chk("lk_pulse", 32'(lockup4), 32'd1);
    chk("lk_count", count4, 32'd1);
    tick();
    chk("lk_pulse_end", 32'(lockup4), 32'd0);

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
